// File: rtl/pio_packer_pkg.sv
// Shared constants for the PIO data-in packer.
//   - lane geometry of the packed 32-bit word
//   - bit positions of the fields inside the 16-bit status word
//   - set_lane(): drop one byte into one lane of a word
package pio_packer_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * LANE_W;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned STATUS_W       = 16;

    localparam int unsigned ST_VALID      = 0;
    localparam int unsigned ST_FULL       = 1;
    localparam int unsigned ST_UNDERFLOW  = 2;
    localparam int unsigned ST_FLUSH_PEND = 3;
    localparam int unsigned ST_IDX_LSB    = 4;
    localparam int unsigned ST_CNT_LSB    = 8;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t set_lane(word_t w, logic [IDX_W-1:0] idx, logic [LANE_W-1:0] b);
        word_t r;
        r = w;
        r[idx*LANE_W +: LANE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/pio_datain_packer_if.sv
// Byte-stream handshake into the packer.
//   byte_data  : incoming byte (master -> slave)
//   byte_valid : byte_data valid this cycle (master -> slave)
//   byte_ready : packer accepts a byte this cycle (slave -> master)
interface pio_datain_packer_if;
    import pio_packer_pkg::*;

    logic [LANE_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/pio_word_fifo.sv
// Synchronous word FIFO, FIFO_DEPTH entries of 32 bits. Same-cycle push and pop are legal.
//   clk, reset_n : clock, async active-low reset
//   push/push_data : write a word (ignored when full unless a pop frees a slot)
//   pop          : drop the head word (ignored when empty)
//   head         : current head word, 0 when empty
//   count/full/empty : occupancy
module pio_word_fifo
    import pio_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  word_t            push_data,
    input  logic             pop,
    output word_t            head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    word_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pio_datain_packer.sv
// Packs a byte stream little-endian into 32-bit words, queues them and presents the head word
// to a PIO input port. Software pops by toggling a PIO output bit.
//   clk, reset_n  : clock, async active-low reset
//   byte_if       : byte stream (byte_data/byte_valid in, byte_ready out)
//   flush         : pulse, push the partial word zero-padded
//   ack_toggle    : each level change pops one word
//   clear_sticky  : pulse, clear the underflow flag
//   data_word     : FIFO head, 0 when empty
//   word_valid    : FIFO not empty
//   status        : [0] valid [1] full [2] underflow [3] flush_pending [5:4] byte_idx [15:8] count
module pio_datain_packer
    import pio_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    pio_datain_packer_if.slave  byte_if,
    input  logic                flush,
    input  logic                ack_toggle,
    input  logic                clear_sticky,
    output word_t               data_word,
    output logic                word_valid,
    output logic [STATUS_W-1:0] status
);

    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    word_t            shift_q, shift_d;
    logic             ack_q;
    logic             underflow_q, underflow_d;
    logic             flush_pending_q, flush_pending_d;

    logic             byte_ready, accept, pop_req, last_lane, can_push;
    logic             fifo_push, fifo_full, fifo_empty;
    word_t            push_word, fifo_head;
    logic [CNT_W-1:0] fifo_count;

    // Registered state only: a full FIFO blocks just the lane-3 byte that would push.
    assign byte_ready         = !(byte_idx_q == IDX_W'(BYTES_PER_WORD - 1) && fifo_full)
                                && !flush_pending_q;
    assign byte_if.byte_ready = byte_ready;

    assign accept    = byte_if.byte_valid && byte_ready;
    assign pop_req   = (ack_toggle != ack_q);
    assign last_lane = accept && (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));
    // Full implies non-empty, so any pop request frees a slot this edge.
    assign can_push  = !fifo_full || pop_req;

    always_comb begin
        shift_d         = shift_q;
        byte_idx_d      = byte_idx_q;
        flush_pending_d = flush_pending_q;
        fifo_push       = 1'b0;
        push_word       = shift_q;

        if (accept) begin
            push_word  = set_lane(shift_q, byte_idx_q, byte_if.byte_data);
            shift_d    = push_word;
            byte_idx_d = byte_idx_q + IDX_W'(1);
        end

        if (last_lane) begin
            fifo_push  = 1'b1;
            shift_d    = '0;
            byte_idx_d = '0;
        end else if ((flush || flush_pending_q) && (byte_idx_q != '0 || accept)) begin
            // Upper lanes are already zero because shift_q is cleared on every push.
            if (can_push) begin
                fifo_push       = 1'b1;
                shift_d         = '0;
                byte_idx_d      = '0;
                flush_pending_d = 1'b0;
            end else begin
                flush_pending_d = 1'b1;
            end
        end

        underflow_d = underflow_q;
        if (clear_sticky)           underflow_d = 1'b0;
        if (pop_req && fifo_empty)  underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q      <= '0;
            shift_q         <= '0;
            ack_q           <= 1'b0;
            underflow_q     <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            byte_idx_q      <= byte_idx_d;
            shift_q         <= shift_d;
            ack_q           <= ack_toggle;
            underflow_q     <= underflow_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    pio_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (pop_req),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_word  = fifo_head;
    assign word_valid = !fifo_empty;

    always_comb begin
        status                           = '0;
        status[ST_VALID]                 = !fifo_empty;
        status[ST_FULL]                  = fifo_full;
        status[ST_UNDERFLOW]             = underflow_q;
        status[ST_FLUSH_PEND]            = flush_pending_q;
        status[ST_IDX_LSB +: IDX_W]      = byte_idx_q;
        status[ST_CNT_LSB +: 8]          = 8'(fifo_count);
    end

endmodule

// File: tb/tb_pio_datain_packer.sv
module tb_pio_datain_packer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        ack_toggle = 1'b0;
    logic        clear_sticky = 1'b0;
    logic [31:0] data_word;
    logic        word_valid;
    logic [15:0] status;

    pio_datain_packer_if bus ();

    pio_datain_packer #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      ($clog2(DEPTH) + 1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .byte_if      (bus),
        .flush        (flush),
        .ack_toggle   (ack_toggle),
        .clear_sticky (clear_sticky),
        .data_word    (data_word),
        .word_valid   (word_valid),
        .status       (status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: bytes of the word being built, queued words, and a few flags.
    logic [7:0]  part_q[$];
    logic [31:0] words_q[$];
    bit          m_ack, m_uflow, m_pend;
    bit          ack_level;

    function automatic bit m_ready();
        return !((part_q.size() == 3) && (words_q.size() == DEPTH)) && !m_pend;
    endfunction

    function automatic logic [31:0] m_pack();
        logic [31:0] w;
        w = '0;
        foreach (part_q[i]) w = w | (32'(part_q[i]) << (8 * i));
        return w;
    endfunction

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s        = '0;
        s[0]     = (words_q.size() != 0);
        s[1]     = (words_q.size() == DEPTH);
        s[2]     = m_uflow;
        s[3]     = m_pend;
        s[5:4]   = 2'(part_q.size());
        s[15:8]  = 8'(words_q.size());
        return s;
    endfunction

    task automatic m_reset();
        part_q.delete();
        words_q.delete();
        m_ack = 0;
        m_uflow = 0;
        m_pend = 0;
    endtask

    // One clock cycle: drive, check byte_ready, clock, advance model, check outputs.
    task automatic step(input bit bv, input logic [7:0] bd, input bit fl, input bit tog,
                        input bit clr);
        bit          acc, pop_req, was_empty, was_full, do_pop, do_push;
        logic [31:0] w;
        bus.byte_valid = bv;
        bus.byte_data  = bd;
        flush          = fl;
        clear_sticky   = clr;
        if (tog) ack_level = ~ack_level;
        ack_toggle = ack_level;
        #1;
        check("byte_ready", 32'(bus.byte_ready), 32'(m_ready()));
        @(posedge clk);
        acc       = bv && m_ready();
        pop_req   = (ack_level != m_ack);
        m_ack     = ack_level;
        was_empty = (words_q.size() == 0);
        was_full  = (words_q.size() == DEPTH);
        do_pop    = pop_req && !was_empty;
        do_push   = 0;
        w         = '0;
        if (acc) part_q.push_back(bd);
        if (part_q.size() == 4) begin
            w = m_pack();
            part_q.delete();
            do_push = 1;
        end else if ((fl || m_pend) && part_q.size() != 0) begin
            if (!was_full || do_pop) begin
                w = m_pack();
                part_q.delete();
                do_push = 1;
                m_pend = 0;
            end else begin
                m_pend = 1;
            end
        end
        if (clr) m_uflow = 0;
        if (pop_req && was_empty) m_uflow = 1;
        if (do_pop) void'(words_q.pop_front());
        if (do_push) words_q.push_back(w);
        #1;
        bus.byte_valid = 1'b0;
        flush          = 1'b0;
        clear_sticky   = 1'b0;
        check("data_word", data_word, (words_q.size() != 0) ? words_q[0] : 32'h0);
        check("word_valid", 32'(word_valid), 32'(words_q.size() != 0));
        check("status", 32'(status), 32'(m_status()));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) step(1, w[8*i +: 8], 0, 0, 0);
    endtask

    // Async reset away from any clock edge; outputs must clear before the next edge.
    task automatic mid_reset();
        #2;
        bus.byte_valid = 1'b0;
        flush = 1'b0;
        clear_sticky = 1'b0;
        ack_level = 0;
        ack_toggle = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_data_word", data_word, 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'h1);
        m_reset();
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] second;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h0;
        ack_level = 0;
        m_reset();
        #3;
        check("init_data_word", data_word, 32'h0);
        check("init_status", 32'(status), 32'h0);
        check("init_byte_ready", 32'(bus.byte_ready), 32'h1);
        #9;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic packing.
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        check("pre_word_valid", 32'(word_valid), 32'h0);
        step(1, 8'h44, 0, 0, 0);
        check("pack_word", data_word, 32'h44332211);
        check("pack_valid", 32'(word_valid), 32'h1);
        check("pack_cnt", 32'(status[15:8]), 32'h1);
        step(0, 0, 0, 1, 0);

        // Fill to full, then back-pressure on lane 3.
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
        check("full_head", data_word, 32'h03020100);
        check("full_flag", 32'(status[1]), 32'h1);
        step(1, 8'h10, 0, 0, 0);
        step(1, 8'h11, 0, 0, 0);
        check("ready_idx2", 32'(bus.byte_ready), 32'h1);
        step(1, 8'h12, 0, 0, 0);
        check("ready_idx3_full", 32'(bus.byte_ready), 32'h0);
        step(1, 8'h13, 0, 0, 0);
        step(1, 8'h13, 0, 1, 0);
        check("ready_after_pop", 32'(bus.byte_ready), 32'h1);
        check("head_after_pop", data_word, 32'h07060504);
        step(1, 8'h13, 0, 0, 0);
        check("fifth_cnt", 32'(status[15:8]), 32'h4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        check("drained", 32'(word_valid), 32'h0);

        // Flush of a partial word, then a no-op flush.
        step(1, 8'hAA, 0, 0, 0);
        step(1, 8'hBB, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("flush_word", data_word, 32'h0000BBAA);
        check("flush_idx", 32'(status[5:4]), 32'h0);
        step(0, 0, 1, 0, 0);
        check("noop_flush_cnt", 32'(status[15:8]), 32'h1);
        step(0, 0, 0, 1, 0);

        // Underflow sticky.
        step(0, 0, 0, 1, 0);
        check("uflow_set", 32'(status[2]), 32'h1);
        check("uflow_cnt", 32'(status[15:8]), 32'h0);
        step(0, 0, 0, 0, 1);
        check("uflow_clr", 32'(status[2]), 32'h0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        check("uflow_wins", 32'(status[2]), 32'h1);
        step(0, 0, 0, 0, 1);

        // Simultaneous push and pop.
        send_word(32'hA4A3A2A1);
        second = 32'hB4B3B2B1;
        send_word(second);
        step(1, 8'hC1, 0, 0, 0);
        step(1, 8'hC2, 0, 0, 0);
        step(1, 8'hC3, 0, 0, 0);
        step(1, 8'hC4, 0, 1, 0);
        check("pushpop_cnt", 32'(status[15:8]), 32'h2);
        check("pushpop_head", data_word, second);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Flush while full.
        for (int i = 0; i < 4; i++) send_word(32'h01010101 * 32'(i + 1));
        step(1, 8'h5A, 0, 0, 0);
        step(1, 8'h5B, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("pend_set", 32'(status[3]), 32'h1);
        check("pend_ready", 32'(bus.byte_ready), 32'h0);
        step(1, 8'h77, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("pend_cnt", 32'(status[15:8]), 32'h4);
        check("pend_clr", 32'(status[3]), 32'h0);
        step(1, 8'h66, 0, 0, 0);
        mid_reset();

        // Randomized traffic: a fill-heavy phase, then a drain-heavy phase.
        for (int i = 0; i < 3000; i++) begin
            int tog_pct;
            tog_pct = (i < 1500) ? 12 : 35;
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) < tog_pct, $urandom_range(0, 19) == 0);
            if (i % 1000 == 999) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
